// File: rtl/keypoint_merge_reader.sv
`default_nettype none
// ============================================================================
// Module   : keypoint_merge_reader
// Brief    : Reads the two raster-ordered keypoint SRAM lists and merges them
//            into one raster-ordered valid/ready stream tagged with its layer.
// Options  : KP_MERGE_DEDUP_EN - equal heads are emitted once (list 1 value).
// Revision : 1.0 - initial release
// ============================================================================
module keypoint_merge_reader #(
   parameter int ADDR_W = 11,
   parameter int CNT_W  = 12,
   parameter int KP_W   = 19,
   parameter int COL_W  = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CNT_W-1:0]  count_1,
   input  logic [CNT_W-1:0]  count_2,
   output logic [ADDR_W-1:0] kp1_addr,
   input  logic [KP_W-1:0]   kp1_dout,
   output logic [ADDR_W-1:0] kp2_addr,
   input  logic [KP_W-1:0]   kp2_dout,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [KP_W-1:0]   out_data,
   output logic              out_layer,
   output logic              out_last,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  total_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FILL = 2'd1,
      S_EMIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt1_q, cnt1_d, cnt2_q, cnt2_d;
   logic [CNT_W-1:0]  rd1_q, rd1_d, rd2_q, rd2_d;
   logic [KP_W-1:0]   head1_q, head1_d, head2_q, head2_d;
   logic              hv1_q, hv1_d, hv2_q, hv2_d;
   logic              pend1_q, pend1_d, pend2_q, pend2_d;
   logic [CNT_W-1:0]  total_q, total_d;
   logic              valid_q, valid_d;
   logic [KP_W-1:0]   data_q, data_d;
   logic              layer_q, layer_d;
   logic              last_q, last_d;
   logic              dup_q, dup_d;
   logic              busy_q, done_q;

   logic              sel_2nd;
   logic              head2_lt_head1;
   logic              exh1, exh2;

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt1_d  = cnt1_q;
      cnt2_d  = cnt2_q;
      rd1_d   = rd1_q;
      rd2_d   = rd2_q;
      head1_d = head1_q;
      head2_d = head2_q;
      hv1_d   = hv1_q;
      hv2_d   = hv2_q;
      pend1_d = pend1_q;
      pend2_d = pend2_q;
      total_d = total_q;

      case (state_q)
         S_IDLE: begin
            rd1_d = '0;
            rd2_d = '0;
            if (start) begin
               cnt1_d  = count_1;
               cnt2_d  = count_2;
               total_d = '0;
               pend1_d = 1'b1;
               pend2_d = 1'b1;
               hv1_d   = 1'b0;
               hv2_d   = 1'b0;
               if ((count_1 == '0) && (count_2 == '0)) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_FILL;
               end
            end
         end

         // The read data now holds the word addressed by rdN last cycle.
         S_FILL: begin
            if (pend1_q) begin
               if (rd1_q < cnt1_q) begin
                  head1_d = kp1_dout;
                  hv1_d   = 1'b1;
                  rd1_d   = rd1_q + CNT_ONE;
               end else begin
                  hv1_d   = 1'b0;
               end
            end
            if (pend2_q) begin
               if (rd2_q < cnt2_q) begin
                  head2_d = kp2_dout;
                  hv2_d   = 1'b1;
                  rd2_d   = rd2_q + CNT_ONE;
               end else begin
                  hv2_d   = 1'b0;
               end
            end
            pend1_d = 1'b0;
            pend2_d = 1'b0;
            state_d = S_EMIT;
         end

         S_EMIT: begin
            if (!hv1_q && !hv2_q) begin
               state_d = S_DONE;
            end else if (valid_q && out_ready) begin
               total_d = total_q + CNT_ONE;
               state_d = S_FILL;
               if (dup_q) begin
                  pend1_d = 1'b1;
                  pend2_d = 1'b1;
               end else if (layer_q) begin
                  pend2_d = 1'b1;
               end else begin
                  pend1_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Head selection, evaluated on next-state values so outputs are registered
   // ---------------------------------------------------------------------
   always_comb begin
      head2_lt_head1 = (head2_d[KP_W-1:COL_W] < head1_d[KP_W-1:COL_W]) ||
                       ((head2_d[KP_W-1:COL_W] == head1_d[KP_W-1:COL_W]) &&
                        (head2_d[COL_W-1:0] < head1_d[COL_W-1:0]));
   end

`ifdef KP_MERGE_DEDUP_EN
   assign dup_d = hv1_d && hv2_d && (head1_d == head2_d);
`else
   assign dup_d = 1'b0;
`endif

   assign exh1    = (rd1_d >= cnt1_d);
   assign exh2    = (rd2_d >= cnt2_d);
   assign sel_2nd = hv2_d && (!hv1_d || head2_lt_head1);

   always_comb begin
      valid_d = (state_d == S_EMIT) && (hv1_d || hv2_d);
      data_d  = sel_2nd ? head2_d : head1_d;
      layer_d = sel_2nd;
      if (dup_d) begin
         last_d = exh1 && exh2;
      end else if (sel_2nd) begin
         last_d = !hv1_d && exh2;
      end else begin
         last_d = !hv2_d && exh1;
      end
   end

   // ---------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt1_q  <= '0;
         cnt2_q  <= '0;
         rd1_q   <= '0;
         rd2_q   <= '0;
         head1_q <= '0;
         head2_q <= '0;
         hv1_q   <= 1'b0;
         hv2_q   <= 1'b0;
         pend1_q <= 1'b0;
         pend2_q <= 1'b0;
         total_q <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         layer_q <= 1'b0;
         last_q  <= 1'b0;
         dup_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt1_q  <= cnt1_d;
         cnt2_q  <= cnt2_d;
         rd1_q   <= rd1_d;
         rd2_q   <= rd2_d;
         head1_q <= head1_d;
         head2_q <= head2_d;
         hv1_q   <= hv1_d;
         hv2_q   <= hv2_d;
         pend1_q <= pend1_d;
         pend2_q <= pend2_d;
         total_q <= total_d;
         valid_q <= valid_d;
         data_q  <= valid_d ? data_d  : '0;
         layer_q <= valid_d ? layer_d : 1'b0;
         last_q  <= valid_d ? last_d  : 1'b0;
         dup_q   <= valid_d ? dup_d   : 1'b0;
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
      end
   end

   // Address forced to 0 in IDLE so a start right after DONE reads entry 0.
   assign kp1_addr    = (state_q == S_IDLE) ? '0 : rd1_q[ADDR_W-1:0];
   assign kp2_addr    = (state_q == S_IDLE) ? '0 : rd2_q[ADDR_W-1:0];
   assign out_valid   = valid_q;
   assign out_data    = data_q;
   assign out_layer   = layer_q;
   assign out_last    = last_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign total_count = total_q;

endmodule
`default_nettype wire

// File: tb/tb_keypoint_merge_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypoint_merge_reader
// Brief    : Randomized bench for keypoint_merge_reader against a list-merge
//            reference model. Honours KP_MERGE_DEDUP_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypoint_merge_reader;

   localparam int ADDR_W = 11;
   localparam int CNT_W  = 12;
   localparam int KP_W   = 19;
   localparam int COL_W  = 10;
   localparam int DEPTH  = 2048;
`ifdef KP_MERGE_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic [CNT_W-1:0]  count_1, count_2;
   logic [ADDR_W-1:0] kp1_addr, kp2_addr;
   logic [KP_W-1:0]   kp1_dout, kp2_dout;
   logic              out_valid, out_ready, out_layer, out_last;
   logic [KP_W-1:0]   out_data;
   logic              busy, done;
   logic [CNT_W-1:0]  total_count;

   always #5 clk = ~clk;

   keypoint_merge_reader #(
      .ADDR_W(ADDR_W), .CNT_W(CNT_W), .KP_W(KP_W), .COL_W(COL_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .count_1(count_1), .count_2(count_2),
      .kp1_addr(kp1_addr), .kp1_dout(kp1_dout),
      .kp2_addr(kp2_addr), .kp2_dout(kp2_dout),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_layer(out_layer), .out_last(out_last),
      .busy(busy), .done(done), .total_count(total_count)
   );

   logic [KP_W-1:0] mem1 [0:DEPTH-1];
   logic [KP_W-1:0] mem2 [0:DEPTH-1];

   always @(posedge clk) begin
      kp1_dout <= mem1[kp1_addr];
      kp2_dout <= mem2[kp2_addr];
   end

   typedef struct packed {
      logic [KP_W-1:0] d;
      logic            layer;
      logic            last;
   } exp_t;

   exp_t expq[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [KP_W-1:0] kp(input int row, input int col);
      logic [KP_W-COL_W-1:0] r;
      logic [COL_W-1:0]      c;
      r = row[KP_W-COL_W-1:0];
      c = col[COL_W-1:0];
      return {r, c};
   endfunction

   // Reference: textbook two-way merge of sorted lists, list 1 winning ties.
   task automatic build_expected(input int c1, input int c2);
      int i, j;
      exp_t e;
      expq.delete();
      i = 0; j = 0;
      while (i < c1 || j < c2) begin
         e.last = 1'b0;
         if (i < c1 && j < c2 && mem1[i] == mem2[j] && DEDUP) begin
            e.d = mem1[i]; e.layer = 1'b0; i++; j++;
         end else if (j >= c2 || (i < c1 && mem1[i] <= mem2[j])) begin
            e.d = mem1[i]; e.layer = 1'b0; i++;
         end else begin
            e.d = mem2[j]; e.layer = 1'b1; j++;
         end
         expq.push_back(e);
      end
      if (expq.size() > 0) expq[expq.size()-1].last = 1'b1;
   endtask

   task automatic fill_random(input int which, input int n, input int step_max);
      int v;
      v = $urandom_range(0, 40);
      for (int i = 0; i < n; i++) begin
         if (which == 1) mem1[i] = KP_W'(v);
         else            mem2[i] = KP_W'(v);
         v += $urandom_range(1, step_max);
      end
   endtask

   task automatic run_merge(input int c1, input int c2, input int stall_pct,
                            input bit stall2nd, input bit check_wrap);
      int n_exp, emitted, cycles, limit, hold;
      bit got_done, stalled, seen_max, seen_wrap;
      logic [KP_W-1:0]   s_data;
      logic              s_layer, s_last;
      logic [ADDR_W-1:0] s_a1, s_a2;
      exp_t e;

      build_expected(c1, c2);
      n_exp = expq.size();
      emitted = 0; cycles = 0; hold = 0;
      got_done = 0; stalled = 0; seen_max = 0; seen_wrap = 0;
      s_data = '0; s_layer = 0; s_last = 0; s_a1 = '0; s_a2 = '0;
      limit = 10 * (c1 + c2) + 20;

      @(negedge clk);
      count_1 = CNT_W'(c1); count_2 = CNT_W'(c2); start = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      while (!got_done && cycles < limit) begin
         if (stall2nd && emitted == 1 && hold < 5 && out_valid) begin
            out_ready = 1'b0; hold++;
         end else begin
            out_ready = ($urandom_range(0, 99) >= stall_pct);
         end
         if (out_valid) begin
            if (stalled) begin
               check_eq("stall_data",  32'(out_data),    32'(s_data));
               check_eq("stall_layer", 32'(out_layer),   32'(s_layer));
               check_eq("stall_last",  32'(out_last),    32'(s_last));
               check_eq("stall_addr1", 32'(kp1_addr),    32'(s_a1));
               check_eq("stall_addr2", 32'(kp2_addr),    32'(s_a2));
               check_eq("stall_total", 32'(total_count), 32'(emitted));
            end
            if (out_ready) begin
               stalled = 0;
               if (expq.size() == 0) begin
                  check_eq("extra_output", 32'(out_data), 32'hFFFF_FFFF);
               end else begin
                  e = expq.pop_front();
                  check_eq("out_data",  32'(out_data),  32'(e.d));
                  check_eq("out_layer", 32'(out_layer), 32'(e.layer));
                  check_eq("out_last",  32'(out_last),  32'(e.last));
               end
               emitted++;
            end else begin
               stalled = 1;
               s_data = out_data; s_layer = out_layer; s_last = out_last;
               s_a1 = kp1_addr; s_a2 = kp2_addr;
            end
         end else if (stalled) begin
            check_eq("valid_dropped", 32'(out_valid), 32'd1);
            stalled = 0;
         end
         if (kp1_addr == ADDR_W'(DEPTH - 1)) seen_max = 1;
         if (seen_max && busy && kp1_addr == '0) seen_wrap = 1;
         if (done) got_done = 1;
         @(negedge clk);
         cycles++;
      end
      out_ready = 1'b0;
      check_eq("done_seen",   32'(got_done),    32'd1);
      check_eq("emitted",     32'(emitted),     32'(n_exp));
      check_eq("total_count", 32'(total_count), 32'(n_exp));
      check_eq("done_width",  32'(done),        32'd0);
      check_eq("idle_busy",   32'(busy),        32'd0);
      if (check_wrap) begin
         check_eq("addr1_max",  32'(seen_max),  32'd1);
         check_eq("addr1_wrap", 32'(seen_wrap), 32'd1);
      end
   endtask

   task automatic reset_mid_emit();
      int hs, cycles;
      bit saw_done;
      fill_random(1, 10, 20);
      hs = 0; cycles = 0; saw_done = 0;
      @(negedge clk);
      count_1 = CNT_W'(10); count_2 = '0; start = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!(hs >= 3 && out_valid) && cycles < 100) begin
         if (out_valid && out_ready) hs++;
         @(negedge clk);
         cycles++;
      end
      check_eq("abort_reached_emit", 32'(out_valid), 32'd1);
      rst_n = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      check_eq("rst_out_valid", 32'(out_valid),   32'd0);
      check_eq("rst_out_data",  32'(out_data),    32'd0);
      check_eq("rst_out_last",  32'(out_last),    32'd0);
      check_eq("rst_out_layer", 32'(out_layer),   32'd0);
      check_eq("rst_busy",      32'(busy),        32'd0);
      check_eq("rst_total",     32'(total_count), 32'd0);
      check_eq("rst_addr1",     32'(kp1_addr),    32'd0);
      check_eq("rst_addr2",     32'(kp2_addr),    32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (done || out_valid) saw_done = 1;
         @(negedge clk);
      end
      check_eq("no_done_after_rst", 32'(saw_done), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
      count_1 = '0; count_2 = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mem1[i] = '0; mem2[i] = '0;
      end
      repeat (3) @(negedge clk);
      check_eq("reset_valid", 32'(out_valid),   32'd0);
      check_eq("reset_done",  32'(done),        32'd0);
      check_eq("reset_busy",  32'(busy),        32'd0);
      check_eq("reset_total", 32'(total_count), 32'd0);
      check_eq("reset_addr1", 32'(kp1_addr),    32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      run_merge(0, 0, 0, 1'b0, 1'b0);

      mem1[0] = kp(5, 10); mem1[1] = kp(5, 20); mem1[2] = kp(7, 1);
      run_merge(3, 0, 0, 1'b0, 1'b0);

      mem1[0] = kp(2, 4); mem1[1] = kp(3, 9);
      mem2[0] = kp(2, 8); mem2[1] = kp(3, 9);
      run_merge(2, 2, 0, 1'b0, 1'b0);

      fill_random(1, 6, 6);
      fill_random(2, 5, 6);
      run_merge(6, 5, 0, 1'b1, 1'b0);

      for (int t = 0; t < 6; t++) begin
         int c1, c2;
         c1 = $urandom_range(0, 40);
         c2 = $urandom_range(0, 40);
         fill_random(1, c1, 6);
         fill_random(2, c2, 6);
         run_merge(c1, c2, 30, 1'b0, 1'b0);
      end

      reset_mid_emit();

      fill_random(1, DEPTH, 100);
      fill_random(2, 1, 100);
      mem2[0] = mem1[1000];
      run_merge(DEPTH, 1, 0, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
